set_assoc_cache: RTL and testbench
==================================

// Module: set_assoc_cache
// PURPOSE
//  Parametrised N-way set-associative, write-through, no-write-allocate data cache.
//  Sits between the core load/store port and the word-wide memory bus.
//  Read misses refill a full line with round-robin victim selection.
//  All writes are forwarded to memory; write hits also update the cached word.
// PARAMETERS
//  ADDR_WIDTH        32  byte address width
//  DATA_WIDTH        32  word width (byte offset fixed at 2 bits)
//  SET_BITS          4   log2(number of sets)
//  BLOCK_OFFSET_BITS 2   log2(words per line)
//  WAYS              4   associativity, power of 2, >=2
//  TAG_WIDTH = ADDR_WIDTH-SET_BITS-BLOCK_OFFSET_BITS-2 (derived, not overridable)
// PORTS
//  clk_i          in   1           clock, all logic on posedge
//  rst_i          in   1           asynchronous, active-high reset
//  req_valid_i    in   1           core request valid
//  req_ready_o    out  1           high only in IDLE; request accepted on valid&ready
//  addr_i         in   ADDR_WIDTH  byte address; [1:0] ignored
//  we_i           in   1           1=write, 0=read
//  wdata_i        in   DATA_WIDTH  write data
//  resp_valid_o   out  1           one-cycle completion pulse (reads and writes)
//  rdata_o        out  DATA_WIDTH  read data, valid only with resp_valid_o on a read
//  mem_req_o      out  1           memory request, held until mem_ack_i
//  mem_we_o       out  1           memory write
//  mem_addr_o     out  ADDR_WIDTH  word-aligned memory address
//  mem_wdata_o    out  DATA_WIDTH  memory write data
//  mem_ack_i      in   1           memory beat accepted/completed
//  mem_rdata_i    in   DATA_WIDTH  read data, valid with mem_ack_i
// BEHAVIOUR
//  Reset: state=IDLE, all valid bits=0, rr_ptr[*]=0, beat=0. Outputs: req_ready_o=1,
//   all other outputs 0. Data/tag arrays are not reset.
//  IDLE: on req_valid_i, latch addr/we/wdata -> COMPARE.
//  COMPARE: hit = valid[set][w] && tag[set][w]==req_tag for any w (at most one match).
//   Read hit: resp_valid_o=1, rdata_o=word, -> IDLE (latency 1 cycle after accept).
//   Read miss: victim=rr_ptr[set], clear its valid bit, beat=0 -> REFILL.
//   Write hit: update the word in that way; write miss: arrays untouched. Both -> WRITE_MEM.
//  REFILL: mem_req_o=1, mem_we_o=0, mem_addr_o={req_tag,set,beat,2'b00}. Each mem_ack_i
//   stores mem_rdata_i into victim[beat] and increments beat. On last ack: set tag,
//   set valid, rr_ptr[set]++ (wraps WAYS-1 -> 0) -> RESP. mem_req_o stays high between
//   beats; the next address is presented the cycle after the ack.
//  WRITE_MEM: mem_req_o=1, mem_we_o=1, addr/wdata from latch; on mem_ack_i -> RESP.
//  RESP: resp_valid_o=1 (on reads rdata_o=requested word) -> IDLE.
//  mem_ack_i is ignored while mem_req_o=0. Memory address/data stay stable until ack.
//  Reset mid-REFILL: line is left invalid and mem_req_o drops immediately. No partial
//   line is ever valid.
//  Hit throughput: one request every 2 cycles.
// CONFIGURATION
//  CACHE_STATS_EN defined: adds outputs hit_count_o[31:0] and miss_count_o[31:0].
//   Each increments once per COMPARE cycle (reads and writes) and saturates at
//   32'hFFFF_FFFF. Reset value is 0.
//  CACHE_STATS_EN undefined: these ports and counters do not exist.
// TESTING
//  1 Reset; read 0x40 -> 4 mem reads at 0x40/44/48/4C, acks return A0..A3; resp
//    rdata=A0. Read 0x44 -> resp 1 cycle after accept, rdata=A1, mem_req_o stays 0.
//  2 After 1, write 0x48=DEADBEEF -> one mem write at 0x48, resp pulse.
//    Read 0x48 -> hit, rdata=DEADBEEF.
//  3 Write 0x1000=12345678 (miss) -> mem write only. Read 0x1000 -> miss and refill
//    (no allocate on write).
//  4 Read 0x40,0x140,0x240,0x340 (set 4 full), then 0x440 -> evicts way0 (tag of 0x40).
//    Read 0x40 -> miss; 0x140 -> hit.
//  5 Assert rst_i after the 2nd refill ack -> mem_req_o=0 and req_ready_o=1 immediately.
//    Re-read the same address -> full 4-beat refill.
//  6 CACHE_STATS_EN: after scenario 1, hit_count_o=1 and miss_count_o=1.
//    Force the counter to FFFF_FFFF, then a hit -> value stays FFFF_FFFF.

Source files
------------

// File: rtl/set_assoc_cache.sv
// N-way set-associative, write-through, no-write-allocate data cache with round-robin refill.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module set_assoc_cache #(
    parameter int unsigned ADDR_WIDTH        = 32,
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned SET_BITS          = 4,
    parameter int unsigned BLOCK_OFFSET_BITS = 2,
    parameter int unsigned WAYS              = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           hit_count_o,
    output logic [31:0]           miss_count_o
`endif
);

    localparam int unsigned TAG_WIDTH = ADDR_WIDTH - SET_BITS - BLOCK_OFFSET_BITS - 2;
    localparam int unsigned SETS      = 1 << SET_BITS;
    localparam int unsigned WORDS     = 1 << BLOCK_OFFSET_BITS;
    localparam int unsigned WAY_BITS  = $clog2(WAYS);

    typedef enum logic [2:0] {StIdle, StCompare, StRefill, StWriteMem, StResp} state_e;

    state_e                         state_q, state_d;
    logic [ADDR_WIDTH-3:0]          waddr_q, waddr_d;
    logic                           we_q, we_d;
    logic [DATA_WIDTH-1:0]          wdata_q, wdata_d;
    logic [BLOCK_OFFSET_BITS-1:0]   beat_q, beat_d;
    logic [WAY_BITS-1:0]            victim_q, victim_d;
    logic [WAYS-1:0]                valid_q [SETS];
    logic [WAYS-1:0]                valid_d [SETS];
    logic [WAY_BITS-1:0]            rr_q [SETS];
    logic [WAY_BITS-1:0]            rr_d [SETS];

    logic [TAG_WIDTH-1:0]           tag_mem  [SETS][WAYS];
    logic [DATA_WIDTH-1:0]          data_mem [SETS][WAYS][WORDS];

    logic [TAG_WIDTH-1:0]           req_tag;
    logic [SET_BITS-1:0]            req_set;
    logic [BLOCK_OFFSET_BITS-1:0]   req_word;
    logic                           hit;
    logic [WAY_BITS-1:0]            hit_way;
    logic                           last_beat;
    logic                           unused_addr_bits;

    assign unused_addr_bits = ^addr_i[1:0];
    assign req_tag   = waddr_q[ADDR_WIDTH-3 -: TAG_WIDTH];
    assign req_set   = waddr_q[BLOCK_OFFSET_BITS +: SET_BITS];
    assign req_word  = waddr_q[BLOCK_OFFSET_BITS-1:0];
    assign last_beat = &beat_q;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_set][w] && tag_mem[req_set][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            waddr_q  <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            beat_q   <= '0;
            victim_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q  <= state_d;
            waddr_q  <= waddr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            beat_q   <= beat_d;
            victim_q <= victim_d;
            valid_q  <= valid_d;
            rr_q     <= rr_d;
        end
    end

    // Tag and data arrays carry no reset; validity alone gates their use.
    always_ff @(posedge clk_i) begin
        if (state_q == StRefill && mem_ack_i) begin
            data_mem[req_set][victim_q][beat_q] <= mem_rdata_i;
            if (last_beat) tag_mem[req_set][victim_q] <= req_tag;
        end
        if (state_q == StCompare && we_q && hit) begin
            data_mem[req_set][hit_way][req_word] <= wdata_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        waddr_d  = waddr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        beat_d   = beat_q;
        victim_d = victim_q;
        valid_d  = valid_q;
        rr_d     = rr_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    waddr_d = addr_i[ADDR_WIDTH-1:2];
                    we_d    = we_i;
                    wdata_d = wdata_i;
                    state_d = StCompare;
                end
            end
            StCompare: begin
                if (we_q) begin
                    state_d = StWriteMem;
                end else if (hit) begin
                    state_d = StIdle;
                end else begin
                    victim_d                    = rr_q[req_set];
                    valid_d[req_set][rr_q[req_set]] = 1'b0;
                    beat_d                      = '0;
                    state_d                     = StRefill;
                end
            end
            StRefill: begin
                if (mem_ack_i) begin
                    beat_d = beat_q + BLOCK_OFFSET_BITS'(1);
                    if (last_beat) begin
                        valid_d[req_set][victim_q] = 1'b1;
                        rr_d[req_set]              = rr_q[req_set] + WAY_BITS'(1);
                        state_d                    = StResp;
                    end
                end
            end
            StWriteMem: if (mem_ack_i) state_d = StResp;
            StResp:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready_o  = (state_q == StIdle);
        resp_valid_o = 1'b0;
        rdata_o      = '0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        unique case (state_q)
            StCompare: begin
                if (!we_q && hit) begin
                    resp_valid_o = 1'b1;
                    rdata_o      = data_mem[req_set][hit_way][req_word];
                end
            end
            StRefill: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {req_tag, req_set, beat_q, 2'b00};
            end
            StWriteMem: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {waddr_q, 2'b00};
                mem_wdata_o = wdata_q;
            end
            StResp: begin
                resp_valid_o = 1'b1;
                if (!we_q) rdata_o = data_mem[req_set][victim_q][req_word];
            end
            default: ;
        endcase
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == StCompare) begin
            if (hit && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
            if (!hit && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache with a simple acking memory model.
// Counter checks are compiled in when CACHE_STATS_EN is defined.
module tb_set_assoc_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, req_ready_o, we_i, resp_valid_o;
    logic [31:0] addr_i, wdata_i, rdata_o;
    logic        mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count_o, miss_count_o;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] rd_log [$];
    logic [31:0] wr_log [$];
    logic [31:0] wr_dat [$];

    always #5 clk = ~clk;

    set_assoc_cache dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .addr_i       (addr_i),
        .we_i         (we_i),
        .wdata_i      (wdata_i),
        .resp_valid_o (resp_valid_o),
        .rdata_o      (rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i)
`ifdef CACHE_STATS_EN
        ,
        .hit_count_o  (hit_count_o),
        .miss_count_o (miss_count_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return 32'hC000_0000 | a;
    endfunction

    // Memory: acks one cycle after seeing a request, then idles one cycle.
    initial begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || mem_ack_i) begin
                mem_ack_i = 1'b0;
            end else if (mem_req_o) begin
                mem_ack_i = 1'b1;
                if (mem_we_o) begin
                    mem_arr[mem_addr_o] = mem_wdata_o;
                    wr_log.push_back(mem_addr_o);
                    wr_dat.push_back(mem_wdata_o);
                end else begin
                    mem_rdata_i = mem_rd(mem_addr_o);
                    rd_log.push_back(mem_addr_o);
                end
            end
        end
    end

    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int lat);
        int guard;
        guard = 0;
        req_valid_i = 1'b1;
        we_i        = we;
        addr_i      = a;
        wdata_i     = d;
        while (!req_ready_o && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        lat = 1;
        while (!resp_valid_o && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!resp_valid_o) check("resp_timeout", 32'd0, 32'd1);
        rd = rdata_o;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;
    int          lat, base, wbase, n;

    initial begin
        mem_arr[32'h40] = 32'h0000_00A0;
        mem_arr[32'h44] = 32'h0000_00A1;
        mem_arr[32'h48] = 32'h0000_00A2;
        mem_arr[32'h4C] = 32'h0000_00A3;
        rst = 1'b1; req_valid_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, req_ready_o}, 32'd1);
        check("rst_resp",  {31'd0, resp_valid_o}, 32'd0);
        check("rst_memreq", {31'd0, mem_req_o}, 32'd0);
        check("rst_memaddr", mem_addr_o, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Read miss refills the whole line, then a neighbouring word hits.
        base = rd_log.size();
        do_req(1'b0, 32'h40, 32'd0, rd, lat);
        check("s1_nreads", 32'(rd_log.size() - base), 32'd4);
        for (int i = 0; i < 4; i++)
            if (rd_log.size() > base + i) check("s1_beat_addr", rd_log[base+i], 32'h40 + 32'(4*i));
        check("s1_rdata", rd, 32'h0000_00A0);
        base = rd_log.size();
        do_req(1'b0, 32'h44, 32'd0, rd, lat);
        check("s1_hit_lat", 32'(lat), 32'd1);
        check("s1_hit_rdata", rd, 32'h0000_00A1);
        check("s1_hit_nomem", 32'(rd_log.size() - base), 32'd0);
`ifdef CACHE_STATS_EN
        check("s6_hits", hit_count_o, 32'd1);
        check("s6_misses", miss_count_o, 32'd1);
`endif

        // Write hit goes through to memory and updates the cached copy.
        wbase = wr_log.size();
        do_req(1'b1, 32'h48, 32'hDEAD_BEEF, rd, lat);
        check("s2_nwrites", 32'(wr_log.size() - wbase), 32'd1);
        if (wr_log.size() > wbase) begin
            check("s2_waddr", wr_log[wbase], 32'h48);
            check("s2_wdata", wr_dat[wbase], 32'hDEAD_BEEF);
        end
        do_req(1'b0, 32'h48, 32'd0, rd, lat);
        check("s2_rd_lat", 32'(lat), 32'd1);
        check("s2_rd_data", rd, 32'hDEAD_BEEF);

        // Write miss does not allocate.
        base = rd_log.size(); wbase = wr_log.size();
        do_req(1'b1, 32'h1000, 32'h1234_5678, rd, lat);
        check("s3_nwrites", 32'(wr_log.size() - wbase), 32'd1);
        check("s3_noreads", 32'(rd_log.size() - base), 32'd0);
        base = rd_log.size();
        do_req(1'b0, 32'h1000, 32'd0, rd, lat);
        check("s3_refill", 32'(rd_log.size() - base), 32'd4);
        check("s3_rdata", rd, 32'h1234_5678);

        // Fill set 4 (0x40 already in way0, rr at way1), then 0x440 evicts way0.
        do_req(1'b0, 32'h40, 32'd0, rd, lat);
        check("s4_40_hit", 32'(lat), 32'd1);
        do_req(1'b0, 32'h140, 32'd0, rd, lat);
        check("s4_140_data", rd, 32'hC000_0140);
        do_req(1'b0, 32'h240, 32'd0, rd, lat);
        do_req(1'b0, 32'h340, 32'd0, rd, lat);
        base = rd_log.size();
        do_req(1'b0, 32'h440, 32'd0, rd, lat);
        check("s4_440_refill", 32'(rd_log.size() - base), 32'd4);
        base = rd_log.size();
        do_req(1'b0, 32'h140, 32'd0, rd, lat);
        check("s4_140_hit", 32'(rd_log.size() - base), 32'd0);
        check("s4_140_rdata", rd, 32'hC000_0140);
        base = rd_log.size();
        do_req(1'b0, 32'h40, 32'd0, rd, lat);
        check("s4_40_miss", 32'(rd_log.size() - base), 32'd4);
        check("s4_40_rdata", rd, 32'h0000_00A0);

`ifdef CACHE_STATS_EN
        force dut.hit_cnt_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.hit_cnt_q;
        do_req(1'b0, 32'h44, 32'd0, rd, lat);
        check("s6_saturate", hit_count_o, 32'hFFFF_FFFF);
`endif

        // Reset in the middle of a refill.
        base = rd_log.size();
        req_valid_i = 1'b1; we_i = 1'b0; addr_i = 32'h800;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        n = 0;
        while (rd_log.size() < base + 2 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("s5_two_beats", 32'(rd_log.size() - base), 32'd2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("s5_memreq_drop", {31'd0, mem_req_o}, 32'd0);
        check("s5_ready", {31'd0, req_ready_o}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        base = rd_log.size();
        do_req(1'b0, 32'h800, 32'd0, rd, lat);
        check("s5_full_refill", 32'(rd_log.size() - base), 32'd4);
        check("s5_rdata", rd, 32'hC000_0800);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
